// File: rtl/apb_master_bridge_if.sv
// Request/response channel and APB3 initiator signals of the bridge.
// The master modport is the bridge view; the slave modport is the requester/peripheral view.
interface apb_master_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        m_psel;
  logic        m_penable;
  logic        m_pwrite;
  logic [31:0] m_paddr;
  logic [31:0] m_pwdata;
  logic        m_pready;
  logic [31:0] m_prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready, m_pready, m_prdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, resp_ready, m_pready, m_prdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding valid/ready to APB3 initiator with a PREADY timeout.
// TIMEOUT = 0 disables the timeout.
module apb_master_bridge #(
  parameter int unsigned TIMEOUT = 256
) (
  input logic                  clk,
  input logic                  rst,
  apb_master_bridge_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  localparam bit          TimeoutEn = (TIMEOUT != 0);
  localparam logic [15:0] WaitLast  = 16'(TIMEOUT - 1);

  state_e      state_q;
  logic [15:0] wait_cnt_q;

  assign bus.req_ready = (state_q == StIdle) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      wait_cnt_q     <= 16'd0;
      bus.m_psel     <= 1'b0;
      bus.m_penable  <= 1'b0;
      bus.m_pwrite   <= 1'b0;
      bus.m_paddr    <= 32'd0;
      bus.m_pwdata   <= 32'd0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= 32'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            bus.m_paddr   <= bus.req_addr;
            bus.m_pwdata  <= bus.req_wdata;
            bus.m_pwrite  <= bus.req_write;
            bus.m_psel    <= 1'b1;
            bus.m_penable <= 1'b0;
            state_q       <= StSetup;
          end
        end
        StSetup: begin
          bus.m_penable <= 1'b1;
          wait_cnt_q    <= 16'd0;
          state_q       <= StAccess;
        end
        StAccess: begin
          // PREADY on the last allowed cycle wins over the timeout.
          if (bus.m_pready) begin
            bus.resp_rdata <= bus.m_pwrite ? 32'd0 : bus.m_prdata;
            bus.resp_err   <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.m_psel     <= 1'b0;
            bus.m_penable  <= 1'b0;
            state_q        <= StResp;
          end else if (TimeoutEn && (wait_cnt_q == WaitLast)) begin
            bus.resp_rdata <= 32'hdeadbeef;
            bus.resp_err   <= 1'b1;
            bus.resp_valid <= 1'b1;
            bus.m_psel     <= 1'b0;
            bus.m_penable  <= 1'b0;
            state_q        <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end
        StResp: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed plus randomized bench for apb_master_bridge with TIMEOUT = 8.
module tb_apb_master_bridge;
  localparam int To = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  apb_master_bridge_if bus ();

  apb_master_bridge #(.TIMEOUT(To)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: a transfer whose peripheral inserts nwait wait states either completes after
  // nwait+1 ACCESS cycles or, if that exceeds the timeout budget, aborts after To cycles.
  function automatic void model(input bit wr, input int nwait, input logic [31:0] prd,
                                output logic [31:0] rd, output bit err, output int cycles);
    if (nwait >= To) begin
      err = 1'b1; rd = 32'hdeadbeef; cycles = To;
    end else begin
      err = 1'b0; rd = wr ? 32'd0 : prd; cycles = nwait + 1;
    end
  endfunction

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int nwait, input logic [31:0] prd, input int rdelay,
                      input bit hold_next);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_cyc;
    int          acc;
    model(wr, nwait, prd, exp_rd, exp_err, exp_cyc);
    chk("idle_req_ready", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    tick();
    chk("setup_psel", bus.m_psel, 1'b1);
    chk("setup_penable", bus.m_penable, 1'b0);
    chk("setup_req_ready", bus.req_ready, 1'b0);
    bus.req_valid = 1'b0;
    tick();
    chk("access_penable", bus.m_penable, 1'b1);
    chk("access_pwrite", bus.m_pwrite, wr);
    chk("access_paddr", bus.m_paddr, addr);
    if (wr) chk("access_pwdata", bus.m_pwdata, wdata);
    acc = 0;
    forever begin
      acc++;
      bus.m_pready = (acc > nwait);
      bus.m_prdata = (acc > nwait) ? prd : $urandom;
      tick();
      if (bus.resp_valid === 1'b1) break;
      chk("wait_penable", bus.m_penable, 1'b1);
      chk("wait_paddr_stable", bus.m_paddr, addr);
      if (acc > 4 * To) begin
        chk("resp_timeout_bound", 32'(acc), 32'(exp_cyc));
        break;
      end
    end
    bus.m_pready = 1'b0;
    chk("access_cycles", 32'(acc), 32'(exp_cyc));
    chk("resp_rdata", bus.resp_rdata, exp_rd);
    chk("resp_err", bus.resp_err, exp_err);
    chk("resp_psel_low", {bus.m_psel, bus.m_penable}, 2'b00);
    if (hold_next) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h0003_0000;
      bus.req_wdata = 32'ha5a5_5a5a;
    end
    for (int i = 0; i < rdelay; i++) begin
      bus.resp_ready = 1'b0;
      tick();
      chk("bp_valid", bus.resp_valid, 1'b1);
      chk("bp_rdata", bus.resp_rdata, exp_rd);
      chk("bp_err", bus.resp_err, exp_err);
      chk("bp_req_ready", bus.req_ready, 1'b0);
      chk("bp_no_psel", bus.m_psel, 1'b0);
    end
    chk("resp_req_ready", bus.req_ready, 1'b0);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk("hs_valid_clear", bus.resp_valid, 1'b0);
    chk("hs_no_accept", bus.m_psel, 1'b0);
  endtask

  initial begin
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_addr   = 32'h1111_2222;
    bus.req_wdata  = 32'h3333_4444;
    bus.resp_ready = 1'b1;
    bus.m_pready   = 1'b1;
    bus.m_prdata   = 32'h5555_6666;

    // Reset held 3 cycles with a request pending.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_req_ready", bus.req_ready, 1'b0);
      chk("rst_ctrl", {bus.m_psel, bus.m_penable, bus.m_pwrite}, 3'b000);
      chk("rst_paddr", bus.m_paddr, 32'd0);
      chk("rst_pwdata", bus.m_pwdata, 32'd0);
      chk("rst_resp", {bus.resp_valid, bus.resp_err}, 2'b00);
      chk("rst_rdata", bus.resp_rdata, 32'd0);
    end
    rst = 1'b0;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    bus.m_pready   = 1'b0;
    #1;
    chk("post_rst_req_ready", bus.req_ready, 1'b1);

    xfer(1'b1, 32'h0001_0004, 32'h1234_5678, 0, 32'h0, 0, 1'b0);
    xfer(1'b0, 32'h0002_0010, 32'h0, 3, 32'hcafe_f00d, 1, 1'b0);
    xfer(1'b0, 32'h0002_0020, 32'h0, To, 32'h0bad_0bad, 0, 1'b0);
    xfer(1'b0, 32'h0002_0030, 32'h0, To - 1, 32'h1357_9bdf, 0, 1'b0);
    xfer(1'b0, 32'h0001_0100, 32'h0, 1, 32'h2468_ace0, 5, 1'b1);
    xfer(1'b1, 32'h0003_0000, 32'ha5a5_5a5a, 0, 32'h0, 0, 1'b0);

    // Reset on the 2nd ACCESS wait cycle discards the transfer.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0000_0040;
    tick();
    bus.req_valid = 1'b0;
    bus.m_pready  = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_access_psel", {bus.m_psel, bus.m_penable}, 2'b00);
    chk("rst_access_valid", bus.resp_valid, 1'b0);
    rst = 1'b0;
    bus.m_pready   = 1'b1;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_access_no_resp", bus.resp_valid, 1'b0);
    end
    bus.m_pready   = 1'b0;
    bus.resp_ready = 1'b0;
    xfer(1'b0, 32'h0000_0044, 32'h0, 2, 32'hfeed_face, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      xfer(1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(0, 10)),
           $urandom, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB initiator that turns single-outstanding valid/ready requests from the CPU/DMA side into APB3 transfers (SETUP then ACCESS) and returns read data or a timeout error on a valid/ready response channel. Its `m_*` outputs drive the upstream (`up_*`) side of the APB interconnect, which fans out to up to four 64 KB peripheral windows. A built-in PREADY timeout guarantees that a hung peripheral cannot stall the requester forever.

## Interface
- `TIMEOUT`, 256: maximum ACCESS cycles waiting for `m_pready`. 0 disables the timeout. Legal range 0..65535.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  bridge can accept a request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  write data.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  requester accepts the response.
- `resp_rdata`  out  32  read data; 0 for writes; 32'hdeadbeef on timeout.
- `resp_err`  out  1  1 = transfer aborted by timeout.
- `m_psel`, `m_penable`, `m_pwrite`  out  1 each  APB control.
- `m_paddr`, `m_pwdata`  out  32 each  APB address and write data.
- `m_pready`  in  1  APB ready.
- `m_prdata`  in  32  APB read data.

## Operation
- State machine has four states: IDLE, SETUP, ACCESS and RESP.
- IDLE:
  - `req_ready` = 1 when `rst` = 0. It is combinational from the state.
  - On `req_valid && req_ready`: latch `req_addr`/`req_wdata`/`req_write` into `m_paddr`/`m_pwdata`/`m_pwrite`; set `m_psel` = 1 and `m_penable` = 0; go to SETUP.
- SETUP:
  - Lasts exactly one cycle.
  - Set `m_penable` = 1, clear the wait counter, and go to ACCESS.
- ACCESS, with `m_pready` = 1:
  - Read: `resp_rdata` <= `m_prdata`. Write: `resp_rdata` <= 0.
  - `resp_err` <= 0, `resp_valid` <= 1, `m_psel` <= 0, `m_penable` <= 0; go to RESP.
- ACCESS, with `m_pready` = 0:
  - If `TIMEOUT` != 0 and counter == `TIMEOUT`-1: abort. Set `resp_rdata` <= 32'hdeadbeef, `resp_err` <= 1, `resp_valid` <= 1, drop `m_psel`/`m_penable`, go to RESP.
  - Otherwise the counter increments. The counter is 16-bit and cannot wrap within a legal `TIMEOUT`.
- RESP:
  - `resp_valid`, `resp_rdata` and `resp_err` are held stable.
  - On `resp_ready` = 1: clear `resp_valid` and go to IDLE.
  - `req_ready` = 0, so no new request is accepted in the same cycle as the response handshake.
- Between SETUP and the end of ACCESS, `m_paddr`, `m_pwdata` and `m_pwrite` do not change. In IDLE they keep their last values.
- Only one transfer is outstanding at any time. There is no pipelining.
- Reset mid-operation: the next edge forces IDLE, drops `m_psel`/`m_penable`, and discards any pending or in-flight response. A peripheral ACCESS aborted this way produces no response.

## Timing
- Reset values:
  - `m_psel`, `m_penable`, `m_pwrite` = 0.
  - `m_paddr`, `m_pwdata` = 0.
  - `resp_valid`, `resp_err` = 0; `resp_rdata` = 0.
  - `req_ready` = 0 while `rst` is high, and 1 in the first cycle after.
- Request accepted at edge T:
  - `m_psel` = 1 in cycle T+1 (SETUP).
  - `m_penable` = 1 from T+2 (ACCESS).
  - With zero wait states, `resp_valid` = 1 at T+3.
- Each cycle of `m_pready` = 0 adds one cycle of latency.
- Timeout: ACCESS lasts exactly `TIMEOUT` cycles, then `resp_valid` = 1 on the following cycle.
- Back-to-back throughput with `resp_ready` held at 1 and zero wait states: one transfer per 4 cycles (IDLE, SETUP, ACCESS, RESP).
- `m_pready` is sampled only in ACCESS and ignored in other states.
- `m_pready` = 1 on the exact cycle the timeout would fire counts as success, not error.

## Test plan
- Reset: hold `rst` for 3 cycles with `req_valid` = 1. Required: no APB activity, all outputs at their reset values, `req_ready` = 0 throughout, and `req_ready` = 1 on the first cycle after release.
- Zero-wait write:
  - Stimulus: addr 0x0001_0004, data 0x1234_5678, `m_pready` = 1.
  - Required: `m_psel` at T+1; `m_penable` at T+2 with `m_pwrite` = 1 and `m_pwdata` = 0x1234_5678; `resp_valid` at T+3 with `resp_rdata` = 0 and `resp_err` = 0.
- Wait-state read:
  - Stimulus: addr 0x0002_0010, `m_pready` low for 3 ACCESS cycles, then high with `m_prdata` = 0xCAFE_F00D.
  - Required: ACCESS lasts 4 cycles; `resp_rdata` = 0xCAFE_F00D; address stable throughout.
- Timeout with `TIMEOUT` = 8 and `m_pready` stuck at 0.
  - Required: `m_penable` high for exactly 8 cycles, then `resp_err` = 1 and `resp_rdata` = 0xDEAD_BEEF.
  - Repeat with `m_pready` rising on the 8th ACCESS cycle. Required: `resp_err` = 0 with the real data.
- Backpressure: hold `resp_ready` = 0 for 5 cycles while `req_valid` stays 1 with a new request. Required: the response is unchanged, `req_ready` = 0, and the new request is accepted only on the cycle after the response handshake.
- Reset in ACCESS: assert `rst` on the 2nd wait cycle. Required: `m_psel`/`m_penable` = 0 next cycle and `resp_valid` never asserts. A following request completes normally.
